// File: rtl/cache_mem_responder.sv
// Burst read/write responder in front of a small word-addressed memory.
// Latency: grant one cycle after request in IDLE; read data combinational from the array in RD_DATA.
// Backpressure: read beats hold while rd_ready=0; write beats accepted whenever wr_valid in WR_DATA.
module cache_mem_responder #(
   parameter int mem_depth  = 32,
   parameter int data_width = 32,
   parameter int addr_width = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rd_req,
   input  logic [addr_width-1:0] rd_addr,
   input  logic [15:0]           rd_len,
   output logic                  rd_gnt,
   output logic                  rd_valid,
   output logic [data_width-1:0] rd_data,
   input  logic                  rd_ready,
   output logic                  rd_done,
   input  logic                  wr_req,
   input  logic [addr_width-1:0] wr_addr,
   input  logic [15:0]           wr_len,
   output logic                  wr_gnt,
   input  logic                  wr_valid,
   input  logic [data_width-1:0] wr_data,
   input  logic                  wr_last,
   output logic                  wr_ready,
   output logic                  wr_done,
   output logic                  len_err,
   output logic                  busy
);

   localparam int IW = $clog2(mem_depth);

   typedef enum logic [2:0] {
      IDLE, RD_GNT, RD_DATA, RD_DONE, WR_GNT, WR_DATA, WR_DONE
   } state_t;

   state_t          state_q, state_d;
   logic [IW-1:0]   addr_q, addr_d;
   logic [15:0]     len_q, len_d;
   logic [16:0]     beat_q, beat_d;
   logic            last_wr_q, last_wr_d;   // 1 = write was the most recent grant

   logic [data_width-1:0] mem_q [mem_depth];

   logic [IW-1:0]   idx;
   logic [16:0]     beat_inc;
   logic            mem_we;

   // Only the low index bits of the request addresses select a word.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{rd_addr[addr_width-1:IW], wr_addr[addr_width-1:IW]};

   // Word index wraps naturally modulo mem_depth; counter saturates at all-ones.
   assign idx      = addr_q + beat_q[IW-1:0];
   assign beat_inc = (beat_q == 17'h1ffff) ? beat_q : beat_q + 17'd1;

   // Next-state, datapath updates and state-decoded outputs.
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      len_d     = len_q;
      beat_d    = beat_q;
      last_wr_d = last_wr_q;
      mem_we    = 1'b0;
      rd_gnt    = 1'b0;
      rd_valid  = 1'b0;
      rd_data   = '0;
      rd_done   = 1'b0;
      wr_gnt    = 1'b0;
      wr_ready  = 1'b0;
      wr_done   = 1'b0;
      len_err   = 1'b0;
      busy      = (state_q != IDLE);
      case (state_q)
         IDLE: begin
            // On a tie the class not granted last wins.
            if (rd_req && (!wr_req || last_wr_q)) begin
               state_d   = RD_GNT;
               last_wr_d = 1'b0;
            end else if (wr_req) begin
               state_d   = WR_GNT;
               last_wr_d = 1'b1;
            end
         end
         RD_GNT: begin
            rd_gnt  = 1'b1;
            addr_d  = rd_addr[IW-1:0];
            len_d   = rd_len;
            beat_d  = '0;
            state_d = (rd_len == 16'd0) ? RD_DONE : RD_DATA;
         end
         RD_DATA: begin
            rd_valid = 1'b1;
            rd_data  = mem_q[idx];
            if (rd_ready) begin
               beat_d = beat_inc;
               if (beat_inc == {1'b0, len_q}) state_d = RD_DONE;
            end
         end
         RD_DONE: begin
            rd_done = 1'b1;
            state_d = IDLE;
         end
         WR_GNT: begin
            wr_gnt  = 1'b1;
            addr_d  = wr_addr[IW-1:0];
            len_d   = wr_len;
            beat_d  = '0;
            state_d = WR_DATA;
         end
         WR_DATA: begin
            wr_ready = 1'b1;
            if (wr_valid) begin
               mem_we = 1'b1;
               beat_d = beat_inc;
               // Only wr_last ends the burst; the declared length is advisory.
               if (wr_last) state_d = WR_DONE;
            end
         end
         WR_DONE: begin
            wr_done = 1'b1;
            len_err = (beat_q != {1'b0, len_q});
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Control registers with synchronous reset; read wins the first tie.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         len_q     <= '0;
         beat_q    <= '0;
         last_wr_q <= 1'b1;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         len_q     <= len_d;
         beat_q    <= beat_d;
         last_wr_q <= last_wr_d;
      end
   end

   // Backing store is never cleared; a reset edge blocks the write of that cycle.
   always_ff @(posedge clk) begin
      if (!rst && mem_we) mem_q[idx] <= wr_data;
   end

endmodule
